// File: rtl/alu_result_stage_pkg.sv
// ----------------------------------------------------------------------------
// alu_result_stage_pkg
//   Shared definitions for the ALU result stage: the ALU control encodings
//   decoded by the top level, the default datapath width, and the occupancy
//   classification used by the result FIFO.
//   No ports (package).
// ----------------------------------------------------------------------------
package alu_result_stage_pkg;

   localparam int ALU_WIDTH_DEF = 32;

   // ALU control encodings (Aluc)
   localparam logic [3:0] ALUC_ADDU = 4'b0000;
   localparam logic [3:0] ALUC_SUBU = 4'b0001;
   localparam logic [3:0] ALUC_AND  = 4'b0010;
   localparam logic [3:0] ALUC_OR   = 4'b0011;
   localparam logic [3:0] ALUC_XOR  = 4'b0100;
   localparam logic [3:0] ALUC_SRL  = 4'b0101;
   localparam logic [3:0] ALUC_LUI  = 4'b0110;
   localparam logic [3:0] ALUC_SLL  = 4'b0111;
   localparam logic [3:0] ALUC_SRA  = 4'b1101;
   localparam logic [3:0] ALUC_SRAV = 4'b1111;

   // FIFO occupancy classes
   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

endpackage

// File: rtl/alu_result_stage_result_fifo.sv
// ----------------------------------------------------------------------------
// result_fifo
//   DEPTH-entry valid/ready FIFO holding selected ALU results. Owns storage,
//   read/write pointers, occupancy count and both handshake outputs. Output
//   data is forced to zero while empty; there is no input-to-output bypass.
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset (control state only)
//   i_push_valid  producer has an entry
//   o_push_ready  FIFO can take an entry this cycle (not full, or popping)
//   i_push_data   entry to store
//   o_pop_valid   head entry valid
//   i_pop_ready   consumer takes the head this cycle
//   o_pop_data    head entry (zero when empty)
// ----------------------------------------------------------------------------
module result_fifo
   import alu_result_stage_pkg::*;
#(
   parameter int DATA_W = 34,
   parameter int DEPTH  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push_valid,
   output logic              o_push_ready,
   input  logic [DATA_W-1:0] i_push_data,
   output logic              o_pop_valid,
   input  logic              i_pop_ready,
   output logic [DATA_W-1:0] o_pop_data
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_PW = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_PW-1:0] FULL_CNT = CNT_PW'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_PW-1:0] r_count;
   occ_e              w_occ;
   logic              w_push;
   logic              w_pop;

   // Pointers wrap explicitly so non-power-of-two depths stay in range.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_occ = OCC_PARTIAL;
      if (r_count == '0)
         w_occ = OCC_EMPTY;
      else if (r_count == FULL_CNT)
         w_occ = OCC_FULL;
   end

   assign o_pop_valid  = (w_occ != OCC_EMPTY);
   // A full FIFO still accepts when the head leaves on the same edge.
   assign o_push_ready = (w_occ != OCC_FULL) | i_pop_ready;
   assign w_push       = i_push_valid & o_push_ready;
   assign w_pop        = o_pop_valid & i_pop_ready;
   assign o_pop_data   = o_pop_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is data only; validity is tracked by the control state above.
   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
//   Registered ALU result selector. Decodes Aluc to pick one of six function
//   unit results, derives zero/illegal flags, and queues {data, zero, illegal}
//   in a DEPTH-entry FIFO toward writeback. Counts accepted illegal codes in a
//   saturating counter.
// Ports
//   Clk, Clrn            clock (rising) / async active-low reset
//   d_and..d_as          function unit results (WIDTH each)
//   Aluc                 4-bit ALU control code
//   in_valid / in_ready  input handshake
//   out_valid/out_ready  output handshake
//   d, zero, illegal     head entry (all zero when out_valid=0)
//   illegal_cnt          saturating count of accepted illegal codes
// ----------------------------------------------------------------------------
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEF,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Clrn,
   input  logic [WIDTH-1:0] d_and,
   input  logic [WIDTH-1:0] d_or,
   input  logic [WIDTH-1:0] d_xor,
   input  logic [WIDTH-1:0] d_lui,
   input  logic [WIDTH-1:0] d_sh,
   input  logic [WIDTH-1:0] d_as,
   input  logic [3:0]       Aluc,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             zero,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   logic [WIDTH-1:0] w_sel_data;
   logic             w_illegal;
   logic             w_zero;
   logic             w_accept;
   logic [WIDTH+1:0] w_fifo_out;
   logic [CNT_W-1:0] r_illegal_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_comb begin
      w_sel_data = '0;
      w_illegal  = 1'b0;
      case (Aluc)
         ALUC_ADDU, ALUC_SUBU:                    w_sel_data = d_as;
         ALUC_AND:                                w_sel_data = d_and;
         ALUC_OR:                                 w_sel_data = d_or;
         ALUC_XOR:                                w_sel_data = d_xor;
         ALUC_LUI:                                w_sel_data = d_lui;
         ALUC_SRL, ALUC_SLL, ALUC_SRA, ALUC_SRAV: w_sel_data = d_sh;
         default:                                 w_illegal  = 1'b1;
      endcase
   end

   assign w_zero   = (w_sel_data == '0);
   assign w_accept = in_valid & in_ready;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn)
         r_illegal_cnt <= '0;
      else if (w_accept && w_illegal)
         r_illegal_cnt <= sat_inc(r_illegal_cnt);
   end

   result_fifo #(
      .DATA_W (WIDTH + 2),
      .DEPTH  (DEPTH)
   ) u_result_fifo (
      .i_clk        (Clk),
      .i_rst_n      (Clrn),
      .i_push_valid (in_valid),
      .o_push_ready (in_ready),
      .i_push_data  ({w_sel_data, w_zero, w_illegal}),
      .o_pop_valid  (out_valid),
      .i_pop_ready  (out_ready),
      .o_pop_data   (w_fifo_out)
   );

   assign d           = w_fifo_out[WIDTH+1:2];
   assign zero        = w_fifo_out[1];
   assign illegal     = w_fifo_out[0];
   assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

   logic        Clk;
   logic        Clrn;
   logic [31:0] d_and, d_or, d_xor, d_lui, d_sh, d_as;
   logic [3:0]  Aluc;
   logic        in_valid, out_ready;
   logic        in_ready, out_valid, zero, illegal;
   logic [31:0] d;
   logic [7:0]  illegal_cnt;
   logic        in_ready2, out_valid2, zero2, illegal2;
   logic [31:0] d2;
   logic [1:0]  illegal_cnt2;

   typedef struct packed {
      logic [31:0] data;
      logic        zero;
      logic        illegal;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          exp_cnt  = 0;
   int          exp_cnt2 = 0;
   logic [34:0] obs, expv;

   alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(8)) dut (
      .Clk(Clk), .Clrn(Clrn), .d_and(d_and), .d_or(d_or), .d_xor(d_xor),
      .d_lui(d_lui), .d_sh(d_sh), .d_as(d_as), .Aluc(Aluc),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .d(d), .zero(zero), .illegal(illegal),
      .illegal_cnt(illegal_cnt)
   );

   alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(2)) dut_c2 (
      .Clk(Clk), .Clrn(Clrn), .d_and(d_and), .d_or(d_or), .d_xor(d_xor),
      .d_lui(d_lui), .d_sh(d_sh), .d_as(d_as), .Aluc(Aluc),
      .in_valid(in_valid), .in_ready(in_ready2), .out_valid(out_valid2),
      .out_ready(out_ready), .d(d2), .zero(zero2), .illegal(illegal2),
      .illegal_cnt(illegal_cnt2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference decode, written from the opcode table.
   function automatic exp_t model(input logic [3:0] c);
      exp_t e;
      e.illegal = 1'b0;
      case (c)
         4'd0, 4'd1:               e.data = d_as;
         4'd2:                     e.data = d_and;
         4'd3:                     e.data = d_or;
         4'd4:                     e.data = d_xor;
         4'd6:                     e.data = d_lui;
         4'd5, 4'd7, 4'd13, 4'd15: e.data = d_sh;
         default: begin e.data = 32'd0; e.illegal = 1'b1; end
      endcase
      e.zero = (e.data == 32'd0);
      return e;
   endfunction

   // One clock: scoreboard push on accept, pop on consume; no comparisons.
   task automatic advance();
      bit acc, pop;
      exp_t e;
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (acc) begin
         e = model(Aluc);
         q.push_back(e);
         if (e.illegal) begin
            if (exp_cnt  != 255) exp_cnt++;
            if (exp_cnt2 != 3)   exp_cnt2++;
         end
      end
      @(posedge Clk);
      #1;
      if (pop && q.size() > 0) void'(q.pop_front());
   endtask

   task automatic test_reset();
      Clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Aluc = 4'd0;
      d_and = '0; d_or = '0; d_xor = '0; d_lui = '0; d_sh = '0; d_as = '0;
      #3;
      n_tests++;
      if ({out_valid, d, zero, illegal} !== 35'd0 || illegal_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_init_outputs: got v=%b d=%h z=%b il=%b cnt=%0d want all 0",
                  out_valid, d, zero, illegal, illegal_cnt);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_init_in_ready: got %b want 1", in_ready);
      end
      @(negedge Clk);
      Clrn = 1'b1;
      // queue two entries, one illegal, then reset mid-stream
      Aluc = 4'b1000; in_valid = 1'b1; advance();
      Aluc = 4'b0010; d_and = 32'h1234_5678; advance();
      n_tests++;
      if (in_ready !== 1'b0 || q.size() != 2 || illegal_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL reset_prefill: got in_ready=%b cnt=%0d want in_ready=0 cnt=1 (queued %0d)",
                  in_ready, illegal_cnt, q.size());
      end
      Clrn = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, d, zero, illegal} !== 35'd0 || illegal_cnt !== 8'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_midstream: got v=%b d=%h cnt=%0d in_ready=%b want v=0 d=0 cnt=0 in_ready=1",
                  out_valid, d, illegal_cnt, in_ready);
      end
      q.delete(); exp_cnt = 0; exp_cnt2 = 0;
      in_valid = 1'b0;
      #2;
      Clrn = 1'b1;
      @(posedge Clk); #1;
   endtask

   task automatic test_and();
      Aluc = 4'b0010; d_and = 32'h0000_00F0; d_or = 32'h0BAD_0001; d_as = 32'h7;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL and_no_bypass: got out_valid=%b want 0", out_valid);
      end
      advance();
      in_valid = 1'b0;
      obs = {out_valid, d, zero, illegal};
      expv = (q.size() != 0) ? {1'b1, q[0]} : 35'd0;
      n_tests++;
      if (obs !== expv || d !== 32'h0000_00F0 || zero !== 1'b0) begin
         n_fail++; $display("FAIL and_head: got %h want %h (d=000000f0 zero=0)", obs, expv);
      end
      advance();
      obs = {out_valid, d, zero, illegal};
      n_tests++;
      if (obs !== 35'd0) begin
         n_fail++; $display("FAIL and_drained: got %h want 0", obs);
      end
   endtask

   task automatic test_zero();
      Aluc = 4'b0001; d_as = 32'd0; d_and = 32'hFFFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
      advance();
      in_valid = 1'b0;
      obs = {out_valid, d, zero, illegal};
      expv = (q.size() != 0) ? {1'b1, q[0]} : 35'd0;
      n_tests++;
      if (obs !== expv || zero !== 1'b1 || illegal !== 1'b0) begin
         n_fail++; $display("FAIL zero_head: got %h want %h", obs, expv);
      end
      advance();
   endtask

   task automatic test_illegal();
      Aluc = 4'b1000; d_and = 32'h5; d_as = 32'h9; d_sh = 32'h3;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         advance();
         obs = {out_valid, d, zero, illegal};
         expv = (q.size() != 0) ? {1'b1, q[0]} : 35'd0;
         n_tests++;
         if (obs !== expv || illegal !== 1'b1 || d !== 32'd0) begin
            n_fail++; $display("FAIL illegal_head_%0d: got %h want %h", i, obs, expv);
         end
      end
      in_valid = 1'b0;
      advance();
      n_tests++;
      if (illegal_cnt !== 8'(exp_cnt) || illegal_cnt !== 8'd3 || illegal_cnt2 !== 2'd3) begin
         n_fail++;
         $display("FAIL illegal_cnt3: got %0d/%0d want %0d/3", illegal_cnt, illegal_cnt2, exp_cnt);
      end
      in_valid = 1'b1; advance();
      in_valid = 1'b0; advance();
      n_tests++;
      if (illegal_cnt !== 8'(exp_cnt) || illegal_cnt2 !== 2'(exp_cnt2) || illegal_cnt2 !== 2'd3) begin
         n_fail++;
         $display("FAIL illegal_cnt_sat: got %0d/%0d want %0d/%0d",
                  illegal_cnt, illegal_cnt2, exp_cnt, exp_cnt2);
      end
   endtask

   task automatic test_full_order();
      out_ready = 1'b0; in_valid = 1'b1;
      Aluc = 4'b0011; d_or = 32'hAAAA_0001; advance();   // A
      Aluc = 4'b0100; d_xor = 32'hBBBB_0002; advance();  // B
      Aluc = 4'b0110; d_lui = 32'hCCCC_0000;             // C presented
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready);
      end
      advance();  // C refused, head must hold A
      obs = {out_valid, d, zero, illegal};
      expv = (q.size() != 0) ? {1'b1, q[0]} : 35'd0;
      n_tests++;
      if (obs !== expv || d !== 32'hAAAA_0001 || q.size() != 2) begin
         n_fail++; $display("FAIL full_hold_A: got %h want %h", obs, expv);
      end
      out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL full_pop_in_ready: got %b want 1", in_ready);
      end
      advance();  // pop A, push C
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         obs = {out_valid, d, zero, illegal};
         expv = (q.size() != 0) ? {1'b1, q[0]} : 35'd0;
         n_tests++;
         if (obs !== expv) begin
            n_fail++; $display("FAIL full_order_%0d: got %h want %h", i, obs, expv);
         end
         advance();
      end
   endtask

   task automatic test_sweep();
      out_ready = 1'b1; in_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
         Aluc  = 4'(c);
         d_and = 32'hA000_0010 + 32'(c);
         d_or  = 32'hB000_0020 + 32'(c);
         d_xor = 32'hC000_0030 + 32'(c);
         d_lui = 32'hD000_0040 + 32'(c);
         d_sh  = 32'hE000_0050 + 32'(c);
         d_as  = 32'hF000_0060 + 32'(c);
         advance();
         obs = {out_valid, d, zero, illegal};
         expv = (q.size() != 0) ? {1'b1, q[0]} : 35'd0;
         n_tests++;
         if (obs !== expv) begin
            n_fail++; $display("FAIL sweep_aluc_%0d: got %h want %h", c, obs, expv);
         end
      end
      in_valid = 1'b0;
      advance();
      n_tests++;
      if (out_valid !== 1'b0 || illegal_cnt !== 8'(exp_cnt) || illegal_cnt2 !== 2'(exp_cnt2)) begin
         n_fail++;
         $display("FAIL sweep_end: got v=%b cnt=%0d/%0d want v=0 cnt=%0d/%0d",
                  out_valid, illegal_cnt, illegal_cnt2, exp_cnt, exp_cnt2);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         Aluc  = 4'($urandom_range(0, 15));
         d_and = $urandom; d_or = $urandom; d_xor = $urandom;
         d_lui = $urandom; d_sh = $urandom;
         d_as  = (i % 7 == 0) ? 32'd0 : $urandom;
         advance();
         obs = {out_valid, d, zero, illegal};
         expv = (q.size() != 0) ? {1'b1, q[0]} : 35'd0;
         n_tests++;
         if (obs !== expv) begin
            n_fail++; $display("FAIL b2b_cycle_%0d: got %h want %h", i, obs, expv);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      advance(); advance();
      n_tests++;
      if (out_valid !== 1'b0 || q.size() != 0 || illegal_cnt !== 8'(exp_cnt)) begin
         n_fail++;
         $display("FAIL b2b_drain: got v=%b cnt=%0d want v=0 cnt=%0d (left %0d)",
                  out_valid, illegal_cnt, exp_cnt, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_and();
      test_zero();
      test_illegal();
      test_full_order();
      test_sweep();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
